// File: rtl/rr_dispatcher.sv
// 1-to-2 round-robin dispatcher: splits one valid/ready stream over ports A and B,
// each with a 2-entry FIFO. Define RR_DISPATCH_STRICT_ALT_EN for strict A,B,A,B alternation.
module rr_dispatcher #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  aclk,
  input  logic                  areset_n,
  input  logic                  prev_valid_i,
  output logic                  prev_ready_o,
  input  logic [DATA_WIDTH-1:0] prev_data_i,
  output logic                  A_next_valid_o,
  input  logic                  A_next_ready_i,
  output logic [DATA_WIDTH-1:0] A_next_data_o,
  output logic                  B_next_valid_o,
  input  logic                  B_next_ready_i,
  output logic [DATA_WIDTH-1:0] B_next_data_o
);

  logic [1:0]            a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic                  a_wr_q, a_wr_d, a_rd_q, a_rd_d;
  logic                  b_wr_q, b_wr_d, b_rd_q, b_rd_d;
  logic                  tgt_q, tgt_d;
  logic [DATA_WIDTH-1:0] a_mem_q [2];
  logic [DATA_WIDTH-1:0] a_mem_d [2];
  logic [DATA_WIDTH-1:0] b_mem_q [2];
  logic [DATA_WIDTH-1:0] b_mem_d [2];

  logic a_space, b_space, sel_b, sel_ok;
  logic push, a_push, b_push, a_pop, b_pop;

  // Space is judged on the registered count only, so ready never depends on the consumers.
  assign a_space = (a_cnt_q != 2'd2);
  assign b_space = (b_cnt_q != 2'd2);

  always_comb begin
    sel_b  = tgt_q;
    sel_ok = 1'b0;
`ifdef RR_DISPATCH_STRICT_ALT_EN
    sel_ok = tgt_q ? b_space : a_space;
`else
    if (tgt_q ? b_space : a_space) begin
      sel_ok = 1'b1;
    end else if (tgt_q ? a_space : b_space) begin
      sel_b  = ~tgt_q;
      sel_ok = 1'b1;
    end
`endif
  end

  assign prev_ready_o   = sel_ok & areset_n;
  assign push           = prev_valid_i & prev_ready_o;
  assign a_push         = push & ~sel_b;
  assign b_push         = push & sel_b;
  assign A_next_valid_o = (a_cnt_q != 2'd0);
  assign B_next_valid_o = (b_cnt_q != 2'd0);
  assign a_pop          = A_next_valid_o & A_next_ready_i;
  assign b_pop          = B_next_valid_o & B_next_ready_i;
  assign A_next_data_o  = A_next_valid_o ? a_mem_q[a_rd_q] : '0;
  assign B_next_data_o  = B_next_valid_o ? b_mem_q[b_rd_q] : '0;

  always_comb begin
    a_cnt_d = a_cnt_q + {1'b0, a_push} - {1'b0, a_pop};
    b_cnt_d = b_cnt_q + {1'b0, b_push} - {1'b0, b_pop};
    a_wr_d  = a_wr_q ^ a_push;
    b_wr_d  = b_wr_q ^ b_push;
    a_rd_d  = a_rd_q ^ a_pop;
    b_rd_d  = b_rd_q ^ b_pop;
    tgt_d   = push ? ~sel_b : tgt_q;
    a_mem_d = a_mem_q;
    b_mem_d = b_mem_q;
    if (a_push) a_mem_d[a_wr_q] = prev_data_i;
    if (b_push) b_mem_d[b_wr_q] = prev_data_i;
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      a_cnt_q <= 2'd0;
      b_cnt_q <= 2'd0;
      a_wr_q  <= 1'b0;
      a_rd_q  <= 1'b0;
      b_wr_q  <= 1'b0;
      b_rd_q  <= 1'b0;
      tgt_q   <= 1'b0;
    end else begin
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
      a_wr_q  <= a_wr_d;
      a_rd_q  <= a_rd_d;
      b_wr_q  <= b_wr_d;
      b_rd_q  <= b_rd_d;
      tgt_q   <= tgt_d;
    end
  end

  // Payload storage carries no reset; outputs are masked to zero while a port is empty.
  always_ff @(posedge aclk) begin
    a_mem_q <= a_mem_d;
    b_mem_q <= b_mem_d;
  end

endmodule

// File: tb/tb_rr_dispatcher.sv
// Self-checking bench for rr_dispatcher: directed table, hand sequences and a
// randomized run against a queue-based reference model.
module tb_rr_dispatcher;
  localparam int DW = 16;

  logic          aclk = 1'b0;
  logic          areset_n;
  logic          prev_valid_i, prev_ready_o;
  logic [DW-1:0] prev_data_i;
  logic          A_next_valid_o, A_next_ready_i;
  logic [DW-1:0] A_next_data_o;
  logic          B_next_valid_o, B_next_ready_i;
  logic [DW-1:0] B_next_data_o;

  always #5 aclk = ~aclk;

  rr_dispatcher #(.DATA_WIDTH(DW)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .prev_valid_i(prev_valid_i), .prev_ready_o(prev_ready_o), .prev_data_i(prev_data_i),
    .A_next_valid_o(A_next_valid_o), .A_next_ready_i(A_next_ready_i), .A_next_data_o(A_next_data_o),
    .B_next_valid_o(B_next_valid_o), .B_next_ready_i(B_next_ready_i), .B_next_data_o(B_next_data_o)
  );

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  logic          tgt_m;
  logic          last_acc;
  logic          last_rdy;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          ar, br;
    logic          er, eav, ebv;
    logic [DW-1:0] ead, ebd;
  } vec_t;
  vec_t tbl[7];

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkd(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Which port the next word should land in, from queue occupancy and the turn pointer.
  function automatic void model_sel(output logic ok, output logic sel);
    logic sa, sb;
    sa  = (qa.size() < 2);
    sb  = (qb.size() < 2);
    sel = tgt_m;
`ifdef RR_DISPATCH_STRICT_ALT_EN
    ok = tgt_m ? sb : sa;
`else
    if (tgt_m ? sb : sa) ok = 1'b1;
    else if (tgt_m ? sa : sb) begin ok = 1'b1; sel = ~tgt_m; end
    else ok = 1'b0;
`endif
  endfunction

  task automatic check_outs();
    chk1("a_valid", A_next_valid_o, qa.size() != 0);
    chk1("b_valid", B_next_valid_o, qb.size() != 0);
    if (qa.size() != 0) chkd("a_data", A_next_data_o, qa[0]);
    if (qb.size() != 0) chkd("b_data", B_next_data_o, qb[0]);
  endtask

  // One clock: drive, check ready before the edge, advance model, check outputs after.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic ar, input logic br);
    logic ok, sel, pa, pb;
    prev_valid_i   = v;
    prev_data_i    = d;
    A_next_ready_i = ar;
    B_next_ready_i = br;
    #1;
    model_sel(ok, sel);
    last_rdy = prev_ready_o;
    chk1("prev_ready", prev_ready_o, ok);
    last_acc = v & ok;
    pa = (qa.size() != 0) && ar;
    pb = (qb.size() != 0) && br;
    @(posedge aclk);
    #1;
    if (pa) void'(qa.pop_front());
    if (pb) void'(qb.pop_front());
    if (last_acc) begin
      if (sel) qb.push_back(d);
      else qa.push_back(d);
      tgt_m = ~sel;
    end
    check_outs();
  endtask

  // Asynchronous reset assert mid-cycle; outputs must clear without an edge.
  task automatic do_reset();
    areset_n = 1'b0;
    #1;
    chk1("rst_a_valid", A_next_valid_o, 1'b0);
    chk1("rst_b_valid", B_next_valid_o, 1'b0);
    chk1("rst_ready", prev_ready_o, 1'b0);
    chkd("rst_a_data", A_next_data_o, '0);
    chkd("rst_b_data", B_next_data_o, '0);
    qa.delete();
    qb.delete();
    tgt_m = 1'b0;
    @(posedge aclk);
    #1;
    areset_n = 1'b1;
  endtask

  initial begin
    int acc;
    areset_n = 1'b0;
    prev_valid_i = 1'b0;
    prev_data_i = '0;
    A_next_ready_i = 1'b0;
    B_next_ready_i = 1'b0;
    tgt_m = 1'b0;
    @(posedge aclk);
    #1;
    do_reset();

    // Alternating stream, both consumers ready.
    tbl[0] = '{1'b1, 16'h0010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000};
    tbl[1] = '{1'b1, 16'h0011, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0011};
    tbl[2] = '{1'b1, 16'h0012, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0012, 16'h0000};
    tbl[3] = '{1'b1, 16'h0013, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0013};
    tbl[4] = '{1'b1, 16'h0014, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0014, 16'h0000};
    tbl[5] = '{1'b1, 16'h0015, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0015};
    tbl[6] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000};
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].ar, tbl[i].br);
      chk1("tbl_ready", last_rdy, tbl[i].er);
      chk1("tbl_a_valid", A_next_valid_o, tbl[i].eav);
      chk1("tbl_b_valid", B_next_valid_o, tbl[i].ebv);
      if (tbl[i].eav) chkd("tbl_a_data", A_next_data_o, tbl[i].ead);
      if (tbl[i].ebv) chkd("tbl_b_data", B_next_data_o, tbl[i].ebd);
    end

    // Both consumers stalled: two words per port, then input stalls.
    do_reset();
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 16'h0020 + 16'(i), 1'b0, 1'b0);
      if (last_acc) acc++;
    end
    chki("both_stall_accepted", acc, 4);
    chk1("both_stall_ready", prev_ready_o, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b1);
    chk1("drained_a", A_next_valid_o, 1'b0);
    chk1("drained_b", B_next_valid_o, 1'b0);

    // Only B stalled: work-conserving keeps flowing, strict stalls on B's turn.
    do_reset();
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 16'h0070 + 16'(i), 1'b1, 1'b0);
      if (last_acc) acc++;
    end
`ifdef RR_DISPATCH_STRICT_ALT_EN
    chki("b_stall_accepted", acc, 5);
    chk1("b_stall_ready", prev_ready_o, 1'b0);
`else
    chki("b_stall_accepted", acc, 6);
    chk1("b_stall_ready", prev_ready_o, 1'b1);
`endif
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b1);

    // Push and pop on port A while it holds one word.
    do_reset();
    step(1'b1, 16'h0030, 1'b0, 1'b0);
    step(1'b1, 16'h0031, 1'b0, 1'b0);
    step(1'b1, 16'h0032, 1'b1, 1'b0);
    chk1("pp_a_valid", A_next_valid_o, 1'b1);
    chkd("pp_a_head", A_next_data_o, 16'h0032);
    step(1'b0, '0, 1'b1, 1'b0);
    chk1("pp_a_empty", A_next_valid_o, 1'b0);

    // Idle cycles do not move the turn pointer.
    do_reset();
    step(1'b1, 16'h0040, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, 16'h0041, 1'b1, 1'b1);
    chk1("idle_b_valid", B_next_valid_o, 1'b1);
    chkd("idle_b_data", B_next_data_o, 16'h0041);
    chk1("idle_a_valid", A_next_valid_o, 1'b0);

    // Reset with both ports full, then first word goes to A.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 16'h0050 + 16'(i), 1'b0, 1'b0);
    chk1("full_a_valid", A_next_valid_o, 1'b1);
    chk1("full_b_valid", B_next_valid_o, 1'b1);
    do_reset();
    step(1'b1, 16'h0060, 1'b1, 1'b1);
    chk1("post_rst_a_valid", A_next_valid_o, 1'b1);
    chkd("post_rst_a_data", A_next_data_o, 16'h0060);
    chk1("post_rst_b_valid", B_next_valid_o, 1'b0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 3) == 0 ? 1'b1 : ($urandom_range(0, 1) == 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
